stopwatch_ctrl: RTL



---
 rtl/stopwatch_pkg.sv | 37 +++
 rtl/bcd_digit.sv | 30 +++
 rtl/stopwatch_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'b100,
    StRunning = 3'b001,
    StPaused  = 3'b010,
    StLap     = 3'b011
  } sw_state_t;

  localparam int unsigned CS_MAX    = 9;
  localparam int unsigned SEC_T_MAX = 5;
  localparam int unsigned MIN_T_MAX = 5;
  localparam int unsigned DIGIT_MAX = 9;

  // Next value of a packed MM:SS.cc BCD time, wrapping 59:59.99 to zero.
  function automatic logic [23:0] sw_time_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3) ? 4'(SEC_T_MAX) : (i == 5) ? 4'(MIN_T_MAX) : 4'(CS_MAX);
      if (carry) begin
        if (r[i*4 +: 4] == lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit 0..MAX with synchronous clear and ripple carry out.
module bcd_digit #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [3:0] o_q,
  output logic       o_carry
);

  localparam logic [3:0] LP_MAX = 4'(MAX);

  logic [3:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 4'd0;
    end else if (i_clr) begin
      r_q <= 4'd0;
    end else if (i_inc) begin
      r_q <= (r_q == LP_MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign o_q     = r_q;
  assign o_carry = i_inc & (r_q == LP_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button sync/edge detect, run/pause/lap FSM, prescaler, BCD time chain.
// Lap feature is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_btn_start,
  input  logic        i_btn_lap,
  input  logic        i_btn_clear,
  output logic [23:0] o_digits,
  output logic [2:0]  o_state,
  output logic        o_running,
  output logic        o_lap_active,
  output logic        o_overflow
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] LP_PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic r_start_s1, r_start_s2, r_start_h;
  logic r_clear_s1, r_clear_s2, r_clear_h;
  logic w_ev_start, w_ev_clear, w_ev_lap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_h  <= 1'b0;
      r_clear_s1 <= 1'b0;
      r_clear_s2 <= 1'b0;
      r_clear_h  <= 1'b0;
    end else begin
      r_start_s1 <= i_btn_start;
      r_start_s2 <= r_start_s1;
      r_start_h  <= r_start_s2;
      r_clear_s1 <= i_btn_clear;
      r_clear_s2 <= r_clear_s1;
      r_clear_h  <= r_clear_s2;
    end
  end

  assign w_ev_start = r_start_s2 & ~r_start_h;
  assign w_ev_clear = r_clear_s2 & ~r_clear_h;

`ifdef STOPWATCH_LAP_EN
  logic r_lap_s1, r_lap_s2, r_lap_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_s1 <= 1'b0;
      r_lap_s2 <= 1'b0;
      r_lap_h  <= 1'b0;
    end else begin
      r_lap_s1 <= i_btn_lap;
      r_lap_s2 <= r_lap_s1;
      r_lap_h  <= r_lap_s2;
    end
  end

  assign w_ev_lap = r_lap_s2 & ~r_lap_h;
`else
  logic w_unused_lap;
  assign w_unused_lap = i_btn_lap;
  assign w_ev_lap     = 1'b0;
`endif

  sw_state_t r_state, w_state_next;
  logic      r_running;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_ev_start) w_state_next = StRunning;
      StRunning: begin
        if (w_ev_start)    w_state_next = StPaused;
        else if (w_ev_lap) w_state_next = StLap;
      end
      StLap: begin
        if (w_ev_start)    w_state_next = StPaused;
        else if (w_ev_lap) w_state_next = StRunning;
      end
      StPaused: begin
        if (w_ev_clear)      w_state_next = StIdle;
        else if (w_ev_start) w_state_next = StRunning;
      end
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == StRunning) || (w_state_next == StLap);
    end
  end

  logic w_enter_idle;
  assign w_enter_idle = (w_state_next == StIdle) && (r_state != StIdle);

  logic [PRE_W-1:0] r_pre;
  logic             w_tick;

  assign w_tick = r_running && (r_pre == LP_PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_enter_idle || w_tick) begin
      r_pre <= '0;
    end else if (r_running) begin
      r_pre <= r_pre + 1'b1;
    end
  end

  logic [3:0] w_cs_o, w_cs_t, w_sec_o, w_sec_t, w_min_o, w_min_t;
  logic [5:0] w_carry;
  logic [23:0] w_live;

  bcd_digit #(.MAX(DIGIT_MAX)) u_cs_o (
    .clk(clk), .rst(rst), .i_inc(w_tick), .i_clr(w_enter_idle),
    .o_q(w_cs_o), .o_carry(w_carry[0])
  );
  bcd_digit #(.MAX(CS_MAX)) u_cs_t (
    .clk(clk), .rst(rst), .i_inc(w_carry[0]), .i_clr(w_enter_idle),
    .o_q(w_cs_t), .o_carry(w_carry[1])
  );
  bcd_digit #(.MAX(DIGIT_MAX)) u_sec_o (
    .clk(clk), .rst(rst), .i_inc(w_carry[1]), .i_clr(w_enter_idle),
    .o_q(w_sec_o), .o_carry(w_carry[2])
  );
  bcd_digit #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .rst(rst), .i_inc(w_carry[2]), .i_clr(w_enter_idle),
    .o_q(w_sec_t), .o_carry(w_carry[3])
  );
  bcd_digit #(.MAX(DIGIT_MAX)) u_min_o (
    .clk(clk), .rst(rst), .i_inc(w_carry[3]), .i_clr(w_enter_idle),
    .o_q(w_min_o), .o_carry(w_carry[4])
  );
  bcd_digit #(.MAX(MIN_T_MAX)) u_min_t (
    .clk(clk), .rst(rst), .i_inc(w_carry[4]), .i_clr(w_enter_idle),
    .o_q(w_min_t), .o_carry(w_carry[5])
  );

  assign w_live = {w_min_t, w_min_o, w_sec_t, w_sec_o, w_cs_t, w_cs_o};

  // Carry out of the top digit only happens on the 59:59.99 wrap.
  logic r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_enter_idle) begin
      r_overflow <= 1'b0;
    end else if (w_carry[5]) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [23:0] r_lap;
  logic        r_lap_active;
  logic        w_enter_lap;

  assign w_enter_lap = (w_state_next == StLap) && (r_state != StLap);

  // Capture the value the chain is writing this edge, so a coincident tick is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap        <= '0;
      r_lap_active <= 1'b0;
    end else begin
      r_lap_active <= (w_state_next == StLap);
      if (w_enter_idle) begin
        r_lap <= '0;
      end else if (w_enter_lap) begin
        r_lap <= w_tick ? sw_time_inc(w_live) : w_live;
      end
    end
  end

  assign o_lap_active = r_lap_active;
  assign o_digits     = r_lap_active ? r_lap : w_live;
`else
  assign o_lap_active = 1'b0;
  assign o_digits     = w_live;
`endif

  assign o_state    = r_state;
  assign o_running  = r_running;
  assign o_overflow = r_overflow;

endmodule
